// File: rtl/snoop_pkg.sv
// Shared encodings for the snoop responder: MESI states, bus ops, snoop results
// and the decision bundle produced by the MESI next-state table.
package snoop_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_e;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_RFO   = 2'd2,
    OP_INVAL = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    RES_NOHIT = 2'b00,
    RES_HIT   = 2'b01,
    RES_HITM  = 2'b10
  } res_e;

  // Outcome of evaluating one snoop against the looked-up line state
  typedef struct packed {
    res_e  res;
    mesi_e next_state;
    logic  upd;
    logic  proto_err;
  } mesi_dec_t;

endpackage

// File: rtl/snoop_responder_if.sv
// Bus bundle between the snoop responder and its surroundings: snooped op in,
// result out, tag lookup/update, writeback and L1 invalidate side channels.
interface snoop_responder_if #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned OFFSET_W = 6,
  parameter int unsigned INDEX_W  = 14,
  parameter int unsigned WAY_W    = 3
);
  localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  logic               snp_valid;
  logic               snp_ready;
  logic [1:0]         snp_op;
  logic [ADDR_W-1:0]  snp_addr;

  logic               res_valid;
  logic [1:0]         res;

  logic               lk_req;
  logic [INDEX_W-1:0] lk_index;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit;
  logic [WAY_W-1:0]   lk_way;
  logic [1:0]         lk_state;

  logic               upd_en;
  logic [INDEX_W-1:0] upd_index;
  logic [WAY_W-1:0]   upd_way;
  logic [1:0]         upd_state;

  logic               wb_valid;
  logic               wb_ready;
  logic [ADDR_W-1:0]  wb_addr;

  logic               l1_inv_valid;
  logic [ADDR_W-1:0]  l1_inv_addr;
  logic               proto_err;
  logic [15:0]        snoop_cnt;
  logic [15:0]        hitm_cnt;

  modport slave (
    input  snp_valid, snp_op, snp_addr, lk_hit, lk_way, lk_state, wb_ready,
    output snp_ready, res_valid, res, lk_req, lk_index, lk_tag,
           upd_en, upd_index, upd_way, upd_state, wb_valid, wb_addr,
           l1_inv_valid, l1_inv_addr, proto_err, snoop_cnt, hitm_cnt
  );

  modport master (
    output snp_valid, snp_op, snp_addr, lk_hit, lk_way, lk_state, wb_ready,
    input  snp_ready, res_valid, res, lk_req, lk_index, lk_tag,
           upd_en, upd_index, upd_way, upd_state, wb_valid, wb_addr,
           l1_inv_valid, l1_inv_addr, proto_err, snoop_cnt, hitm_cnt
  );

endinterface

// File: rtl/snoop_mesi_next.sv
// Combinational MESI snoop table: result, next state, whether the state
// changes, and illegal-state detection for INVALIDATE on an owned line.
module snoop_mesi_next
  import snoop_pkg::*;
(
  input  op_e       op,
  input  logic      hit,
  input  mesi_e     state,
  output mesi_dec_t dec_c
);

  // Misses (or I lines) and WRITE ops leave the line untouched
  always_comb begin
    dec_c = '{res: RES_NOHIT, next_state: state, upd: 1'b0, proto_err: 1'b0};
    if (hit && (state != MESI_I)) begin
      case (op)
        OP_READ: begin
          dec_c.next_state = MESI_S;
          dec_c.res        = (state == MESI_M) ? RES_HITM : RES_HIT;
        end
        OP_RFO: begin
          dec_c.next_state = MESI_I;
          dec_c.res        = (state == MESI_M) ? RES_HITM : RES_HIT;
        end
        OP_INVAL: begin
          dec_c.next_state = MESI_I;
          dec_c.res        = RES_HIT;
          dec_c.proto_err  = (state == MESI_E) || (state == MESI_M);
        end
        default: ;
      endcase
      dec_c.upd = (dec_c.next_state != state);
    end
  end

endmodule

// File: rtl/snoop_responder.sv
// Snoop responder: accepts one snooped bus op at a time, looks up the tag
// array, answers NOHIT/HIT/HITM, updates the line state and, for dirty hits,
// writes the line back before updating.
// Optional feature: define SNOOP_L1_INVAL_EN to emit L1 invalidates whenever
// a line is written to I; otherwise l1_inv_valid/l1_inv_addr are tied to 0.
module snoop_responder
  import snoop_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned OFFSET_W = 6,
  parameter int unsigned INDEX_W  = 14,
  parameter int unsigned WAY_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  snoop_responder_if.slave    bus
);

  localparam int unsigned TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned LINE_W = ADDR_W - OFFSET_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_EVAL,
    ST_WB,
    ST_DONE
  } fsm_e;

  fsm_e              state_q, state_d;
  logic              ready_q;
  logic              lk_req_q;
  op_e               op_q;
  logic [LINE_W-1:0] line_q;
  logic [WAY_W-1:0]  way_q;
  mesi_e             wb_state_q;
  logic [CNT_W-1:0]  snoop_cnt_q;
  logic [CNT_W-1:0]  hitm_cnt_q;

  logic              accept_c;
  logic              hitm_c;
  logic              res_valid_c;
  res_e              res_c;
  logic              upd_en_c;
  logic [WAY_W-1:0]  upd_way_c;
  mesi_e             upd_state_c;
  logic              proto_err_c;
  mesi_dec_t         dec_c;
  logic [ADDR_W-1:0] line_addr_c;
  logic              unused_c;

  assign accept_c    = ready_q && bus.snp_valid;
  assign line_addr_c = {line_q, {OFFSET_W{1'b0}}};
  assign unused_c    = ^bus.snp_addr[OFFSET_W-1:0];

  snoop_mesi_next u_mesi_next (
    .op    (op_q),
    .hit   (bus.lk_hit),
    .state (mesi_e'(bus.lk_state)),
    .dec_c (dec_c)
  );

  // Next state and per-state outputs; a dirty hit defers its update to the WB handshake
  always_comb begin
    state_d     = state_q;
    res_valid_c = 1'b0;
    res_c       = RES_NOHIT;
    upd_en_c    = 1'b0;
    upd_way_c   = way_q;
    upd_state_c = MESI_I;
    proto_err_c = 1'b0;
    hitm_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = (op_e'(bus.snp_op) == OP_WRITE) ? ST_DONE : ST_LOOKUP;
        end
      end
      ST_LOOKUP: state_d = ST_EVAL;
      ST_EVAL: begin
        res_valid_c = 1'b1;
        res_c       = dec_c.res;
        proto_err_c = dec_c.proto_err;
        if (dec_c.res == RES_HITM) begin
          hitm_c  = 1'b1;
          state_d = ST_WB;
        end else begin
          upd_en_c    = dec_c.upd;
          upd_way_c   = bus.lk_way;
          upd_state_c = dec_c.next_state;
          state_d     = ST_IDLE;
        end
      end
      ST_WB: begin
        if (bus.wb_ready) begin
          upd_en_c    = 1'b1;
          upd_state_c = wb_state_q;
          state_d     = ST_IDLE;
        end
      end
      ST_DONE: begin
        res_valid_c = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus captured op, line and pending writeback context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      lk_req_q   <= 1'b0;
      op_q       <= OP_READ;
      line_q     <= '0;
      way_q      <= '0;
      wb_state_q <= MESI_I;
    end else begin
      state_q  <= state_d;
      ready_q  <= (state_d == ST_IDLE);
      lk_req_q <= (state_d == ST_LOOKUP);
      if (accept_c) begin
        op_q   <= op_e'(bus.snp_op);
        line_q <= bus.snp_addr[ADDR_W-1:OFFSET_W];
      end
      if (hitm_c) begin
        way_q      <= bus.lk_way;
        wb_state_q <= dec_c.next_state;
      end
    end
  end

  // Saturating activity counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snoop_cnt_q <= '0;
      hitm_cnt_q  <= '0;
    end else begin
      if (accept_c && (snoop_cnt_q != '1)) snoop_cnt_q <= snoop_cnt_q + CNT_W'(1);
      if (hitm_c && (hitm_cnt_q != '1))    hitm_cnt_q  <= hitm_cnt_q + CNT_W'(1);
    end
  end

  assign bus.snp_ready = ready_q;
  assign bus.res_valid = res_valid_c;
  assign bus.res       = res_c;
  assign bus.lk_req    = lk_req_q;
  assign bus.lk_index  = line_q[INDEX_W-1:0];
  assign bus.lk_tag    = line_q[LINE_W-1 -: TAG_W];
  assign bus.upd_en    = upd_en_c;
  assign bus.upd_index = line_q[INDEX_W-1:0];
  assign bus.upd_way   = upd_way_c;
  assign bus.upd_state = upd_state_c;
  assign bus.wb_valid  = (state_q == ST_WB);
  assign bus.wb_addr   = line_addr_c;
  assign bus.proto_err = proto_err_c;
  assign bus.snoop_cnt = snoop_cnt_q;
  assign bus.hitm_cnt  = hitm_cnt_q;

`ifdef SNOOP_L1_INVAL_EN
  // L1 invalidate accompanies every state write to I
  assign bus.l1_inv_valid = upd_en_c && (upd_state_c == MESI_I);
  assign bus.l1_inv_addr  = bus.l1_inv_valid ? line_addr_c : '0;
`else
  assign bus.l1_inv_valid = 1'b0;
  assign bus.l1_inv_addr  = '0;
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// Scoreboard bench for snoop_responder: the driver pushes the expected outcome
// of every snoop, a monitor pops and compares whenever the DUT responds.
module tb_snoop_responder;
  import snoop_pkg::*;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned OFFSET_W = 6;
  localparam int unsigned INDEX_W  = 14;
  localparam int unsigned WAY_W    = 3;

`ifdef SNOOP_L1_INVAL_EN
  localparam bit L1_EN = 1'b1;
`else
  localparam bit L1_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic [1:0]        st;
    logic [WAY_W-1:0]  way;
    int                dly;
    logic [1:0]        res;
    logic [1:0]        nst;
    logic              upd;
    logic              perr;
    int                acc_cyc;
    int                lat;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snoop_responder_if #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W), .WAY_W(WAY_W)) bus ();

  snoop_responder #(.ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W), .WAY_W(WAY_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  txn_t exp_q[$];
  txn_t wb_q[$];
  txn_t cur;
  txn_t mt;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int snoop_m = 0, hitm_m = 0, lk_exp = 0, lk_cnt = 0;
  int wb_cnt = 0, wb_cyc = 0;
  logic exp_l1, mon_upd_seen;
  logic [ADDR_W-1:0] exp_line;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return (a >> OFFSET_W) << OFFSET_W;
  endfunction

  // Reference: snoop outcome straight from the MESI protocol rules
  function automatic txn_t model(input logic [1:0] op, input logic [ADDR_W-1:0] addr, input logic hit,
                                 input logic [1:0] st, input logic [WAY_W-1:0] way, input int dly);
    txn_t t;
    t.op = op; t.addr = addr; t.hit = hit; t.st = st; t.way = way; t.dly = dly;
    t.res = RES_NOHIT; t.nst = st; t.upd = 1'b0; t.perr = 1'b0; t.acc_cyc = 0;
    t.lat = (op == OP_WRITE) ? 1 : 2;
    if (op != OP_WRITE && hit && st != MESI_I) begin
      t.nst  = (op == OP_READ) ? MESI_S : MESI_I;
      t.res  = (st == MESI_M && op != OP_INVAL) ? RES_HITM : RES_HIT;
      t.perr = (op == OP_INVAL) && (st == MESI_E || st == MESI_M);
      t.upd  = (t.nst != st);
    end
    return t;
  endfunction

  always @(posedge clk) cyc++;

  // Tag array stand-in: answers each lookup in the following cycle, junk otherwise
  always @(negedge clk) begin
    if (rst_n && bus.lk_req) begin
      lk_cnt++;
      chk("lk_index", bus.lk_index, (cur.addr >> OFFSET_W) % (1 << INDEX_W));
      chk("lk_tag", bus.lk_tag, cur.addr >> (OFFSET_W + INDEX_W));
      bus.lk_hit   = cur.hit;
      bus.lk_state = cur.st;
      bus.lk_way   = cur.way;
    end else if (bus.snp_valid) begin
      bus.lk_hit   = 1'($urandom);
      bus.lk_state = 2'($urandom);
      bus.lk_way   = WAY_W'($urandom);
    end
  end

  // Writeback sink: holds wb_ready low for the op's chosen delay
  always @(negedge clk) begin
    if (rst_n && bus.wb_valid) begin
      bus.wb_ready = (wb_cnt >= cur.dly);
      wb_cnt++;
    end else begin
      bus.wb_ready = 1'($urandom);
      wb_cnt = 0;
    end
  end

  // Monitor: samples late in each cycle, after all bench drivers have settled
  always begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      exp_q.delete();
      wb_q.delete();
      wb_cyc = 0;
    end else begin
      exp_l1 = 1'b0;
      exp_line = '0;
      mon_upd_seen = 1'b0;
      if (bus.res_valid) begin
        if (exp_q.size() == 0) chk("res_unexpected", bus.res_valid, 0);
        else begin
          mt = exp_q.pop_front();
          chk("res", bus.res, mt.res);
          chk("latency", cyc - mt.acc_cyc, mt.lat);
          chk("proto_err", bus.proto_err, mt.perr);
          mon_upd_seen = 1'b1;
          if (mt.res == RES_HITM) begin
            wb_q.push_back(mt);
            chk("upd_en_eval_hitm", bus.upd_en, 0);
          end else begin
            chk("upd_en", bus.upd_en, mt.upd);
            if (mt.upd && bus.upd_en) begin
              chk("upd_state", bus.upd_state, mt.nst);
              chk("upd_way", bus.upd_way, mt.way);
              chk("upd_index", bus.upd_index, (mt.addr >> OFFSET_W) % (1 << INDEX_W));
              exp_l1 = L1_EN && (mt.nst == MESI_I);
              exp_line = line_of(mt.addr);
            end
          end
        end
      end else if (bus.proto_err) chk("proto_err_stray", bus.proto_err, 0);
      if (bus.wb_valid) begin
        if (wb_q.size() == 0) chk("wb_unexpected", bus.wb_valid, 0);
        else begin
          mt = wb_q[0];
          wb_cyc++;
          chk("wb_addr", bus.wb_addr, line_of(mt.addr));
          if (bus.wb_ready) begin
            chk("wb_cycles", wb_cyc, mt.dly + 1);
            chk("upd_en_wb", bus.upd_en, 1);
            chk("upd_state_wb", bus.upd_state, mt.nst);
            chk("upd_way_wb", bus.upd_way, mt.way);
            chk("upd_index_wb", bus.upd_index, (mt.addr >> OFFSET_W) % (1 << INDEX_W));
            exp_l1 = L1_EN && (mt.nst == MESI_I);
            exp_line = line_of(mt.addr);
            mon_upd_seen = 1'b1;
            void'(wb_q.pop_front());
            wb_cyc = 0;
          end
        end
      end
      if (!mon_upd_seen && bus.upd_en) chk("upd_en_stray", bus.upd_en, 0);
      if (exp_l1 || bus.l1_inv_valid) chk("l1_inv_valid", bus.l1_inv_valid, exp_l1);
      if (exp_l1) chk("l1_inv_addr", bus.l1_inv_addr, exp_line);
    end
  end

  // Present one snoop for a single cycle once the responder is ready
  task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] addr, input logic hit,
                       input logic [1:0] st, input logic [WAY_W-1:0] way, input int dly);
    txn_t t;
    int n = 0;
    @(negedge clk);
    while (!bus.snp_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.snp_ready) begin
      chk("snp_ready_timeout", bus.snp_ready, 1);
      return;
    end
    t = model(op, addr, hit, st, way, dly);
    t.acc_cyc = cyc;
    cur = t;
    exp_q.push_back(t);
    if (snoop_m < 16'hFFFF) snoop_m++;
    if (t.res == RES_HITM && hitm_m < 16'hFFFF) hitm_m++;
    if (op != OP_WRITE) lk_exp++;
    bus.snp_valid = 1'b1;
    bus.snp_op    = op;
    bus.snp_addr  = addr;
    @(negedge clk);
    bus.snp_valid = 1'b0;
    bus.snp_op    = 2'($urandom);
    bus.snp_addr  = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    #4;
    while (!(bus.snp_ready && exp_q.size() == 0 && wb_q.size() == 0) && n < 200) begin
      @(negedge clk);
      #4;
      n++;
    end
    chk("idle_reached", n < 200, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    bus.snp_valid = 1'b0;
    bus.snp_op    = '0;
    bus.snp_addr  = '0;
    bus.lk_hit    = 1'b0;
    bus.lk_way    = '0;
    bus.lk_state  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_snp_ready", bus.snp_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_lk_req", bus.lk_req, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_upd_en", bus.upd_en, 0);
    chk("rst_snoop_cnt", bus.snoop_cnt, 0);
    chk("rst_hitm_cnt", bus.hitm_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    issue(OP_READ,  32'h0000_1040, 1'b1, MESI_E, 3'd2, 0);
    issue(OP_RFO,   32'h0000_2080, 1'b1, MESI_M, 3'd6, 3);
    issue(OP_INVAL, 32'h0000_30C0, 1'b1, MESI_E, 3'd1, 0);
    issue(OP_WRITE, 32'hDEAD_BEEF, 1'b1, MESI_M, 3'd4, 0);
    issue(OP_RFO,   32'h0000_1040, 1'b1, MESI_S, 3'd5, 0);
    issue(OP_READ,  32'h0000_5000, 1'b1, MESI_S, 3'd0, 0);
    issue(OP_READ,  32'h0000_6000, 1'b0, MESI_M, 3'd0, 0);
    wait_idle();
    chk("snoop_cnt_directed", bus.snoop_cnt, snoop_m);
    chk("hitm_cnt_directed", bus.hitm_cnt, hitm_m);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      issue(2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), WAY_W'($urandom), $urandom_range(0, 4));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    chk("snoop_cnt_random", bus.snoop_cnt, snoop_m);
    chk("hitm_cnt_random", bus.hitm_cnt, hitm_m);

    // Reset in the middle of a writeback
    issue(OP_RFO, 32'h0000_4440, 1'b1, MESI_M, 3'd3, 40);
    n = 0;
    while (!bus.wb_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wb_reached", bus.wb_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_wb_valid", bus.wb_valid, 0);
    chk("abort_upd_en", bus.upd_en, 0);
    chk("abort_snoop_cnt", bus.snoop_cnt, 0);
    chk("abort_hitm_cnt", bus.hitm_cnt, 0);
    chk("abort_snp_ready", bus.snp_ready, 0);
    snoop_m = 0;
    hitm_m  = 0;
    @(posedge clk);
    #1;
    chk("abort_upd_en_edge", bus.upd_en, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Recovery after reset
    issue(OP_READ, 32'h0000_7FC0, 1'b1, MESI_M, 3'd7, 1);
    wait_idle();
    chk("snoop_cnt_final", bus.snoop_cnt, snoop_m);
    chk("hitm_cnt_final", bus.hitm_cnt, hitm_m);
    chk("lookup_count", lk_cnt, lk_exp);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("wb_q_drained", wb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snoop_responder.md
SNOOP_RESPONDER -- requirements
Module: snoop_responder

Interface
REQ-001 SHALL have parameter ADDR_W, 32, bus address width.
REQ-002 SHALL have parameter OFFSET_W, 6, line offset width.
REQ-003 SHALL have parameter INDEX_W, 14, set index width; TAG_W = ADDR_W-INDEX_W-OFFSET_W (derived).
REQ-004 SHALL have parameter WAY_W, 3, way number width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-006 SHALL have ports: snp_valid  in  1  snooped bus op present; snp_ready  out  1  responder can accept; snp_op  in  2  bus op; snp_addr  in  ADDR_W  op address.
REQ-007 SHALL have ports: res_valid  out  1  result pulse; res  out  2  snoop result.
REQ-008 SHALL have ports: lk_req  out  1  tag lookup; lk_index  out  INDEX_W; lk_tag  out  TAG_W; lk_hit  in  1; lk_way  in  WAY_W; lk_state  in  2  MESI of hit way.
REQ-009 SHALL have ports: upd_en  out  1  state write; upd_index  out  INDEX_W; upd_way  out  WAY_W; upd_state  out  2.
REQ-010 SHALL have ports: wb_valid  out  1; wb_ready  in  1; wb_addr  out  ADDR_W  line-aligned writeback address.
REQ-011 SHALL have ports: l1_inv_valid  out  1; l1_inv_addr  out  ADDR_W; proto_err  out  1  illegal-state pulse; snoop_cnt  out  16; hitm_cnt  out  16.

Function
REQ-012 SHALL use encodings: MESI I=00, S=01, E=10, M=11; op READ=0, WRITE=1, RFO=2, INVALIDATE=3; result NOHIT=00, HIT=01, HITM=10.
REQ-013 SHALL implement FSM IDLE, LOOKUP, EVAL, WB, DONE; snp_ready=1 only in IDLE.
REQ-014 IDLE: on snp_valid&snp_ready, SHALL capture op/addr; WRITE -> DONE, else -> LOOKUP.
REQ-015 LOOKUP: SHALL assert lk_req one cycle with index/tag from captured addr -> EVAL.
REQ-016 EVAL: SHALL sample lk_* (valid one cycle after lk_req), pulse res_valid with result, then -> WB if HITM else IDLE.
REQ-017 Miss (lk_hit=0 or lk_state=I) SHALL give NOHIT, no update.
REQ-018 READ: M->S HITM; E->S HIT; S->S HIT (no upd_en when state unchanged).
REQ-019 RFO: M->I HITM; E/S->I HIT.
REQ-020 INVALIDATE: S->I HIT; E or M SHALL pulse proto_err, result HIT, next state I, no writeback.
REQ-021 Non-HITM updates SHALL assert upd_en in EVAL; HITM update SHALL assert upd_en in the WB handshake cycle.
REQ-022 WB: wb_valid held, wb_addr={tag,index,0} stable, until wb_ready; then -> IDLE.
REQ-023 DONE: SHALL pulse res_valid with NOHIT -> IDLE (WRITE latency 1, others 2 cycles from accept).
REQ-024 snoop_cnt SHALL increment per accepted op; hitm_cnt per HITM; both saturate at 16'hFFFF.

Reset
REQ-025 rst_n low SHALL force IDLE, all outputs and counters 0 immediately, aborting any pending WB without update.

Configuration
REQ-026 With SNOOP_L1_INVAL_EN defined, SHALL pulse l1_inv_valid with line address in the cycle upd_en writes I; undefined, l1_inv_valid/l1_inv_addr tied 0.

Structure
REQ-027 MESI, op and result encodings SHALL live in shared package snoop_pkg.
REQ-028 Next-state/result table SHALL be combinational sub-module snoop_mesi_next; no other sub-modules.

Verification
REQ-029 READ addr 32'h0000_1040, lk_state=E -> res=HIT at accept+2, upd_state=S, no wb.
REQ-030 RFO, lk_state=M, wb_ready low 3 cycles -> HITM, wb_valid 4 cycles, upd_en=I on handshake, hitm_cnt=1.
REQ-031 INVALIDATE, lk_state=E -> proto_err pulse, res=HIT, upd_state=I.
REQ-032 WRITE any addr -> res=NOHIT at accept+1, no lk_req.
REQ-033 rst_n low during WB -> wb_valid 0 same cycle, no upd_en, counters 0.
REQ-034 With SNOOP_L1_INVAL_EN, RFO on S -> l1_inv_valid with addr 32'h0000_1040 in upd_en cycle.
